frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
- Responder end of the rasterizer pixel-write interface (frame_rd_en / frame_x / frame_y / px_color, with frame_ready back-pressure).
- Double-buffered frame store controller in front of a single-port pixel memory: raster writes land in the back buffer, the display scan reads the front buffer.
- raster_done arms a buffer swap, which executes on the next vsync pulse.
- Display scan reads take priority over raster writes; the writer is stalled via frame_ready.

Parameters:
- H_RES, 640, visible pixels per row.
- V_RES, 480, visible rows.
- FB_SIZE, 307200, words per buffer (H_RES*V_RES); buffer 1 base address = FB_SIZE.
- ADDR_W, 20, memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- frame_rd_en  in  1  raster pixel write request.
- frame_x  in  10  write column.
- frame_y  in  9  write row.
- px_color  in  3  write color.
- frame_ready  out  1  write accepted this cycle when high together with frame_rd_en.
- raster_done  in  1  single-cycle pulse: back buffer frame complete.
- vsync  in  1  single-cycle pulse at start of vertical blank.
- scan_req  in  1  display read request.
- scan_x  in  10  display read column.
- scan_y  in  9  display read row.
- scan_color  out  3  display read data.
- scan_valid  out  1  scan_color valid strobe.
- front_sel  out  1  index of the buffer being displayed.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  3  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  3  read data, valid the cycle after mem_re.

Behaviour:
- Reset values: front_sel=0, swap_pending=0, scan_valid=0, scan_color=0, state=DRAW. Combinational outputs evaluate to mem_we=0, mem_re=0, frame_ready=0 for the cycle in which rst is high.
- Pixel offset = y*H_RES + x, computed as (y<<9)+(y<<7)+x, zero-extended to ADDR_W. Buffer base = 0 or FB_SIZE.
- FSM states:
  - DRAW: writer allowed.
  - SWAP_WAIT: raster_done seen, waiting for vsync.
- frame_ready (combinational) = (state==DRAW) & ~scan_req & ~rst.
- Write path, zero latency: when frame_rd_en & frame_ready:
  - mem_we=1, mem_addr = back base + offset, mem_wdata = px_color. Back base uses ~front_sel.
  - Out-of-range coordinates (x>=H_RES or y>=V_RES) are still handshaken (accepted), but mem_we=0 (pixel discarded).
- Scan path:
  - scan_req=1 → mem_re=1, mem_addr = front base + scan offset, same cycle. The scan request wins over any write.
  - Edge T samples the request. mem_rdata is captured into scan_color at edge T+1. scan_valid is high for one cycle after T+1, i.e. latency 2 clocks.
  - Back-to-back scan_req is allowed (fully pipelined).
  - Out-of-range scan coordinates return scan_color=0, with scan_valid still pulsed and mem_re=0.
- Transitions:
  - DRAW, raster_done & ~vsync → SWAP_WAIT.
  - DRAW, raster_done & vsync → toggle front_sel at that edge; stay in DRAW.
  - SWAP_WAIT, vsync → toggle front_sel, go to DRAW. frame_ready is high (absent scan_req) from the next cycle.
  - SWAP_WAIT, raster_done → ignored (no double swap).
  - vsync in DRAW without raster_done → no effect.
- front_sel toggling never affects an in-flight scan read: its address was already issued.
- Reset mid-operation returns to DRAW with front_sel=0. Any pending swap is lost, and the in-flight scan pulse is dropped (scan_valid=0 the following cycle).

Optional Feature:
- Macro FB_STALL_CNT_EN.
- When defined:
  - Extra output stall_cnt [31:0] counts cycles where frame_rd_en & ~frame_ready.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst and at every front_sel toggle.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then write (x=3,y=2,color=5) with no scan → same cycle frame_ready=1, mem_we=1, mem_addr=FB_SIZE+1283, mem_wdata=5.
- scan_req (x=0,y=1) held with frame_rd_en high → frame_ready=0, mem_re=1, mem_addr=640. With mem_rdata=6 the next cycle, scan_valid=1 with scan_color=6 two cycles after the request.
- raster_done pulse, vsync 10 cycles later → frame_ready=0 for those 10 cycles; front_sel goes 0→1 at the vsync edge; a subsequent write at (0,0) goes to mem_addr=0.
- raster_done and vsync in the same cycle from DRAW → front_sel toggles immediately; frame_ready stays high the next cycle.
- Write at x=640,y=0 and at x=0,y=480 → frame_ready=1 for both, mem_we=0 for both.
- Assert rst while in SWAP_WAIT with a scan read in flight → front_sel=0, state DRAW, scan_valid=0 the next cycle; with FB_STALL_CNT_EN, stall_cnt=0.

Source files
------------

// File: rtl/frame_buffer_ctrl_if.sv
// ---------------------------------------------------------------------------
// frame_buffer_ctrl_if
// Raster pixel-write handshake between the rasterizer (master) and the frame
// buffer controller (slave). A pixel is transferred in any cycle where
// frame_rd_en and frame_ready are both high.
//
// Signals:
//   frame_rd_en  master->slave  pixel write request
//   frame_x      master->slave  write column (10 bits)
//   frame_y      master->slave  write row (9 bits)
//   px_color     master->slave  write color (3 bits)
//   frame_ready  slave->master  write accepted this cycle
// ---------------------------------------------------------------------------
interface frame_buffer_ctrl_if;
  logic       frame_rd_en;
  logic [9:0] frame_x;
  logic [8:0] frame_y;
  logic [2:0] px_color;
  logic       frame_ready;

  modport master (
    output frame_rd_en,
    output frame_x,
    output frame_y,
    output px_color,
    input  frame_ready
  );

  modport slave (
    input  frame_rd_en,
    input  frame_x,
    input  frame_y,
    input  px_color,
    output frame_ready
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// frame_buffer_ctrl
// Double-buffered frame store controller in front of a single-port pixel
// memory. Raster writes go to the back buffer, display scan reads come from
// the front buffer. raster_done arms a swap that executes on the next vsync.
// Scan reads have priority over writes; the writer is stalled via frame_ready.
//
// Optional feature macro: FB_STALL_CNT_EN
//   When defined, adds output stall_cnt[31:0] counting cycles in which the
//   writer requests but is not accepted (saturating, cleared on reset and on
//   every front buffer swap).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr            raster write handshake (frame_buffer_ctrl_if.slave)
//   raster_done   back buffer frame complete pulse
//   vsync         start of vertical blank pulse
//   scan_req      display read request, scan_x/scan_y read coordinate
//   scan_color    display read data, qualified by scan_valid (2-clock latency)
//   front_sel     buffer currently displayed
//   mem_*         single-port pixel memory (read data valid cycle after mem_re)
//   stall_cnt     writer stall counter (FB_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module frame_buffer_ctrl #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int FB_SIZE = 307200,
  parameter int ADDR_W  = 20
) (
  input  logic                clk,
  input  logic                rst,
  frame_buffer_ctrl_if.slave  wr,
  input  logic                raster_done,
  input  logic                vsync,
  input  logic                scan_req,
  input  logic [9:0]          scan_x,
  input  logic [8:0]          scan_y,
  output logic [2:0]          scan_color,
  output logic                scan_valid,
  output logic                front_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2:0]          mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [2:0]          mem_rdata
`ifdef FB_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic [0:0] {
    DRAW      = 1'b0,
    SWAP_WAIT = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_SIZE);
  localparam logic [9:0]        X_LIMIT   = 10'(H_RES);
  localparam logic [8:0]        Y_LIMIT   = 9'(V_RES);

  state_t state, next_state;
  logic   do_swap;
  logic   swap_pending;

  logic   scan_p1;
  logic   scan_rng_p1;

  logic   wr_in_range;
  logic   scan_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] scan_addr;

  // y*640 + x built from shifts (512 + 128 = 640), so the row stride is
  // tied to the default H_RES.
  function automatic logic [ADDR_W-1:0] pix_offset(input logic [9:0] x,
                                                   input logic [8:0] y);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = ADDR_W'(y);
    xw = ADDR_W'(x);
    return (yw << 9) + (yw << 7) + xw;
  endfunction

  // A pending swap is exactly the SWAP_WAIT state.
  assign swap_pending = (state == SWAP_WAIT);

  assign wr_in_range   = (wr.frame_x < X_LIMIT) && (wr.frame_y < Y_LIMIT);
  assign scan_in_range = (scan_x < X_LIMIT) && (scan_y < Y_LIMIT);

  // Writes land in the back buffer (~front_sel), reads in the front buffer.
  assign wr_addr   = (front_sel ? '0 : BUF1_BASE) + pix_offset(wr.frame_x, wr.frame_y);
  assign scan_addr = (front_sel ? BUF1_BASE : '0) + pix_offset(scan_x, scan_y);

  assign wr.frame_ready = swap_pending ? 1'b0 : (~scan_req & ~rst);

  // Memory port: scan read wins; out-of-range accesses are handshaken but
  // never touch memory.
  always_comb begin
    mem_addr  = wr_addr;
    mem_wdata = wr.px_color;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (scan_req && !rst) begin
      mem_addr = scan_addr;
      mem_re   = scan_in_range;
    end else if (wr.frame_rd_en && wr.frame_ready) begin
      mem_we   = wr_in_range;
    end
  end

  // Swap FSM next-state logic.
  always_comb begin
    next_state = state;
    do_swap    = 1'b0;
    case (state)
      DRAW: begin
        if (raster_done) begin
          if (vsync) begin
            do_swap = 1'b1;
          end else begin
            next_state = SWAP_WAIT;
          end
        end
      end
      SWAP_WAIT: begin
        if (vsync) begin
          do_swap    = 1'b1;
          next_state = DRAW;
        end
      end
      default: next_state = DRAW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRAW;
      front_sel <= 1'b0;
    end else begin
      state <= next_state;
      if (do_swap) begin
        front_sel <= ~front_sel;
      end
    end
  end

  // Two-stage scan pipeline: stage 1 remembers the request and whether it
  // actually read memory; stage 2 captures mem_rdata (or 0 for off-screen).
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_p1     <= 1'b0;
      scan_rng_p1 <= 1'b0;
      scan_valid  <= 1'b0;
      scan_color  <= '0;
    end else begin
      scan_p1     <= scan_req;
      scan_rng_p1 <= scan_in_range;
      scan_valid  <= scan_p1;
      if (scan_p1) begin
        scan_color <= scan_rng_p1 ? mem_rdata : 3'd0;
      end
    end
  end

`ifdef FB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || do_swap) begin
      stall_cnt <= '0;
    end else if (wr.frame_rd_en && !wr.frame_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_ctrl
// Self-checking bench for frame_buffer_ctrl: a table of single-cycle
// combinational vectors plus hand-written multi-cycle sequences for scan
// latency, buffer swaps and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_frame_buffer_ctrl;

  localparam int FB_SIZE = 307200;

  logic        clk;
  logic        rst;
  logic        raster_done;
  logic        vsync;
  logic        scan_req;
  logic [9:0]  scan_x;
  logic [8:0]  scan_y;
  logic [2:0]  scan_color;
  logic        scan_valid;
  logic        front_sel;
  logic [19:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  mem_rdata;
`ifdef FB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  frame_buffer_ctrl_if wr_if();

  frame_buffer_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr_if),
    .raster_done (raster_done),
    .vsync       (vsync),
    .scan_req    (scan_req),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .scan_color  (scan_color),
    .scan_valid  (scan_valid),
    .front_sel   (front_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
`ifdef FB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [2:0]  color;
    logic        scan;
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic        exp_ready;
    logic        exp_we;
    logic        exp_re;
    logic        chk_addr;
    logic [19:0] exp_addr;
    logic [2:0]  exp_wdata;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd_en, input logic [9:0] x,
                               input logic [8:0] y, input logic [2:0] color,
                               input logic scan, input logic [9:0] sx,
                               input logic [8:0] sy);
    wr_if.frame_rd_en = rd_en;
    wr_if.frame_x     = x;
    wr_if.frame_y     = y;
    wr_if.px_color    = color;
    scan_req          = scan;
    scan_x            = sx;
    scan_y            = sy;
    #1;
  endtask

  task automatic checkStall(input string name, input logic [31:0] expected);
`ifdef FB_STALL_CNT_EN
    checkOutput(name, stall_cnt, expected);
`else
    if (expected == 32'hFFFF_FFFF) $display("[TB] %s not built", name);
`endif
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    raster_done  = 1'b0;
    vsync        = 1'b0;
    mem_rdata    = 3'd0;

    // Vectors assume front_sel=0, so the back buffer sits at FB_SIZE.
    vecs[0] = '{1'b1, 10'd3,    9'd2,   3'd5, 1'b0, 10'd0,   9'd0,   1'b1, 1'b1, 1'b0, 1'b1, 20'(FB_SIZE + 1283),   3'd5};
    vecs[1] = '{1'b1, 10'd639,  9'd479, 3'd7, 1'b0, 10'd0,   9'd0,   1'b1, 1'b1, 1'b0, 1'b1, 20'(FB_SIZE + 307199), 3'd7};
    vecs[2] = '{1'b1, 10'd640,  9'd0,   3'd2, 1'b0, 10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 20'd0,                 3'd2};
    vecs[3] = '{1'b1, 10'd0,    9'd480, 3'd1, 1'b0, 10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 20'd0,                 3'd1};
    vecs[4] = '{1'b1, 10'd5,    9'd5,   3'd4, 1'b1, 10'd0,   9'd1,   1'b0, 1'b0, 1'b1, 1'b1, 20'd640,               3'd4};
    vecs[5] = '{1'b0, 10'd0,    9'd0,   3'd0, 1'b1, 10'd639, 9'd479, 1'b0, 1'b0, 1'b1, 1'b1, 20'd307199,            3'd0};
    vecs[6] = '{1'b1, 10'd1,    9'd1,   3'd6, 1'b1, 10'd640, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 20'd0,                 3'd6};
    vecs[7] = '{1'b0, 10'd0,    9'd0,   3'd0, 1'b0, 10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 20'd0,                 3'd0};
    vecs[8] = '{1'b1, 10'd0,    9'd0,   3'd3, 1'b0, 10'd0,   9'd0,   1'b1, 1'b1, 1'b0, 1'b1, 20'(FB_SIZE),          3'd3};
    vecs[9] = '{1'b1, 10'd1023, 9'd511, 3'd2, 1'b0, 10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 20'd0,                 3'd2};

    // Reset: combinational outputs suppressed while rst is high.
    applyStimulus(1'b1, 10'd3, 9'd2, 3'd5, 1'b1, 10'd0, 9'd1);
    tick();
    checkOutput("rst_ready", wr_if.frame_ready, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_re", mem_re, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 10'd0, 9'd0);
    checkOutput("rst_front_sel", front_sel, 0);
    checkOutput("rst_scan_valid", scan_valid, 0);
    checkOutput("rst_scan_color", scan_color, 0);
    checkOutput("rst_idle_ready", wr_if.frame_ready, 1);
    checkStall("rst_stall_cnt", 0);

    // Table-driven combinational vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rd_en, vecs[i].x, vecs[i].y, vecs[i].color,
                    vecs[i].scan, vecs[i].sx, vecs[i].sy);
      checkOutput($sformatf("vec%0d_ready", i), wr_if.frame_ready, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d_we", i), mem_we, vecs[i].exp_we);
      checkOutput($sformatf("vec%0d_re", i), mem_re, vecs[i].exp_re);
      if (vecs[i].chk_addr)
        checkOutput($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_we)
        checkOutput($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      tick();
    end
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 10'd0, 9'd0);
    tick();
    tick();

    // Scan read latency: request at edge T, data captured at T+1.
    applyStimulus(1'b1, 10'd3, 9'd2, 3'd5, 1'b1, 10'd0, 9'd1);
    checkOutput("scan_ready", wr_if.frame_ready, 0);
    checkOutput("scan_re", mem_re, 1);
    checkOutput("scan_addr", mem_addr, 640);
    tick();
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 10'd0, 9'd0);
    mem_rdata = 3'd6;
    checkOutput("scan_valid_t1", scan_valid, 0);
    tick();
    mem_rdata = 3'd0;
    checkOutput("scan_valid_t2", scan_valid, 1);
    checkOutput("scan_color_t2", scan_color, 6);
    tick();
    checkOutput("scan_valid_t3", scan_valid, 0);

    // Back-to-back scans, then an off-screen scan returning zero.
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b1, 10'd5, 9'd0);
    tick();
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b1, 10'd640, 9'd0);
    mem_rdata = 3'd3;
    checkOutput("oob_scan_re", mem_re, 0);
    tick();
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 10'd0, 9'd0);
    mem_rdata = 3'd7;
    checkOutput("b2b_valid0", scan_valid, 1);
    checkOutput("b2b_color0", scan_color, 3);
    tick();
    mem_rdata = 3'd0;
    checkOutput("oob_valid", scan_valid, 1);
    checkOutput("oob_color", scan_color, 0);
    tick();

    // Armed swap: raster_done, then vsync ten cycles later.
    doReset();
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 10'd0, 9'd0);
    raster_done = 1'b1;
    checkOutput("arm_ready", wr_if.frame_ready, 1);
    tick();
    raster_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b1, 10'd0, 9'd0, 3'd1, 1'b0, 10'd0, 9'd0);
      raster_done = (c == 5);
      vsync       = (c == 10);
      checkOutput($sformatf("wait%0d_ready", c), wr_if.frame_ready, 0);
      checkOutput($sformatf("wait%0d_we", c), mem_we, 0);
      checkOutput($sformatf("wait%0d_front", c), front_sel, 0);
      if (c == 10) checkStall("wait_stall_cnt", 9);
      tick();
    end
    raster_done = 1'b0;
    vsync       = 1'b0;
    applyStimulus(1'b1, 10'd0, 9'd0, 3'd2, 1'b0, 10'd0, 9'd0);
    checkOutput("swap_front_sel", front_sel, 1);
    checkOutput("swap_ready", wr_if.frame_ready, 1);
    checkOutput("swap_we", mem_we, 1);
    checkOutput("swap_addr", mem_addr, 0);
    checkStall("swap_stall_cleared", 0);

    // Front buffer 1: scan (0,0) must read from FB_SIZE.
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b1, 10'd0, 9'd0);
    checkOutput("front1_scan_addr", mem_addr, FB_SIZE);
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 10'd0, 9'd0);

    // raster_done and vsync together from DRAW: immediate toggle.
    raster_done = 1'b1;
    vsync       = 1'b1;
    tick();
    raster_done = 1'b0;
    vsync       = 1'b0;
    applyStimulus(1'b1, 10'd0, 9'd0, 3'd4, 1'b0, 10'd0, 9'd0);
    checkOutput("imm_front_sel", front_sel, 0);
    checkOutput("imm_ready", wr_if.frame_ready, 1);
    checkOutput("imm_addr", mem_addr, FB_SIZE);
    tick();

    // vsync alone in DRAW does nothing.
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    #1;
    checkOutput("vsync_only_front", front_sel, 0);
    checkOutput("vsync_only_ready", wr_if.frame_ready, 1);

    // Reset while in SWAP_WAIT with a scan read in flight.
    raster_done = 1'b1;
    vsync       = 1'b1;
    tick();
    vsync = 1'b0;
    #1;
    checkOutput("pre_rst_front", front_sel, 1);
    tick();
    raster_done = 1'b0;
    applyStimulus(1'b1, 10'd0, 9'd0, 3'd0, 1'b1, 10'd2, 9'd0);
    checkOutput("pre_rst_swap_wait", wr_if.frame_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", wr_if.frame_ready, 0);
    checkOutput("mid_rst_we", mem_we, 0);
    checkOutput("mid_rst_re", mem_re, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 10'd0, 9'd0);
    checkOutput("post_rst_scan_valid", scan_valid, 0);
    checkOutput("post_rst_front", front_sel, 0);
    checkOutput("post_rst_ready", wr_if.frame_ready, 1);
    checkStall("post_rst_stall_cnt", 0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    #1;
    checkOutput("post_rst_no_swap", front_sel, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
